// File: rtl/kalman_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : kalman_pkg
//  Description : Shared types and constants for the Kalman filter front end:
//                sensor identifiers, scheduler state encoding, axis geometry.
//  Revision    : 1.0  initial release
// ============================================================================
package kalman_pkg;

    localparam int AXIS_W    = 16;
    localparam int N_AXES    = 3;
    localparam int N_SENSORS = 3;

    typedef enum logic [1:0] {
        ACC  = 2'd0,
        GYRO = 2'd1,
        MAG  = 2'd2
    } sensor_id_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        WAIT   = 2'd2,
        COMMIT = 2'd3
    } sched_state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter3.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter3
//  Description : Combinational three-way round-robin arbiter. Picks the first
//                eligible requester after last_served in the cyclic order
//                ACC -> GYRO -> MAG.
//  Ports       : eligible    in  3  request vector, bit n = sensor id n
//                last_served in  2  sensor granted most recently
//                grant       out 2  selected sensor (don't-care if !grant_valid)
//                grant_valid out 1  at least one requester is eligible
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter3
    import kalman_pkg::*;
(
    input  logic [2:0]  eligible,
    input  sensor_id_t  last_served,
    output sensor_id_t  grant,
    output logic        grant_valid
);

    always_comb begin
        grant       = ACC;
        grant_valid = |eligible;
        case (last_served)
            ACC: begin
                if (eligible[1])      grant = GYRO;
                else if (eligible[2]) grant = MAG;
                else                  grant = ACC;
            end
            GYRO: begin
                if (eligible[2])      grant = MAG;
                else if (eligible[0]) grant = ACC;
                else                  grant = GYRO;
            end
            default: begin
                if (eligible[0])      grant = ACC;
                else if (eligible[1]) grant = GYRO;
                else                  grant = MAG;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sensor_read_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : sensor_read_scheduler
//  Description : Shares one register-read bus master between accelerometer,
//                gyroscope and magnetometer. Each granted sensor gets three
//                axis reads; the triple is published with a ready flag that
//                the consumer clears with a read acknowledge. Includes a
//                per-word bus timeout and data-ready overrun detection.
//  Ports       : clk, n_rst (sync, active-low), configured
//                acc/gyro/mag_drdy  in   data-ready levels
//                bus_start/bus_sensor/bus_reg  out  read request
//                bus_done/bus_rdata            in   read response
//                acc/gyro/mag_ready out, acc/gyro/mag_read in
//                acc/gyro/mag_data  out  48-bit {z, y, x}
//                overrun, bus_timeout  out  one-cycle event pulses
//  Revision    : 1.0  initial release
// ============================================================================
module sensor_read_scheduler
    import kalman_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     configured,
    input  logic                     acc_drdy,
    input  logic                     gyro_drdy,
    input  logic                     mag_drdy,
    output logic                     bus_start,
    output logic [1:0]               bus_sensor,
    output logic [1:0]               bus_reg,
    input  logic                     bus_done,
    input  logic [AXIS_W-1:0]        bus_rdata,
    output logic                     acc_ready,
    output logic                     gyro_ready,
    output logic                     mag_ready,
    input  logic                     acc_read,
    input  logic                     gyro_read,
    input  logic                     mag_read,
    output logic [N_AXES*AXIS_W-1:0] acc_data,
    output logic [N_AXES*AXIS_W-1:0] gyro_data,
    output logic [N_AXES*AXIS_W-1:0] mag_data,
    output logic                     overrun,
    output logic                     bus_timeout
);

    localparam int                 c_CNT_W    = $clog2(TIMEOUT + 1);
    localparam int                 c_DATA_W   = N_AXES * AXIS_W;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(TIMEOUT);

    sched_state_t          r_state;
    sensor_id_t            r_grant;
    sensor_id_t            r_last;
    logic [1:0]            r_axis;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [2:0]            r_pending;
    logic [2:0]            r_ready;
    logic [AXIS_W-1:0]     r_shadow [N_AXES];
    logic [c_DATA_W-1:0]   r_data   [N_SENSORS];
    logic                  r_bus_start;
    logic [1:0]            r_bus_sensor;
    logic [1:0]            r_bus_reg;
    logic                  r_overrun;
    logic                  r_timeout;

    logic [2:0]            w_drdy;
    logic [2:0]            w_read;
    logic [2:0]            w_eligible;
    logic [2:0]            w_grant_oh;
    sensor_id_t            w_grant;
    logic                  w_grant_valid;
    logic                  w_commit;
    logic                  w_abort;

    assign w_drdy     = {mag_drdy, gyro_drdy, acc_drdy};
    assign w_read     = {mag_read, gyro_read, acc_read};
    // Unconsumed data is never overwritten, so a sensor with ready set waits.
    assign w_eligible = r_pending & ~r_ready;
    assign w_grant_oh = 3'b001 << r_grant;
    assign w_commit   = (r_state == COMMIT);
    // The abort fires on the edge where the counter would reach TIMEOUT,
    // which places the pulse exactly TIMEOUT cycles after WAIT entry.
    assign w_abort    = (r_state == WAIT) && !bus_done && (r_cnt == c_CNT_LAST);

    rr_arbiter3 u_arb (
        .eligible    (w_eligible),
        .last_served (r_last),
        .grant       (w_grant),
        .grant_valid (w_grant_valid)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state      <= IDLE;
            r_grant      <= ACC;
            r_last       <= MAG;
            r_axis       <= 2'd0;
            r_cnt        <= '0;
            r_pending    <= 3'b000;
            r_ready      <= 3'b000;
            r_bus_start  <= 1'b0;
            r_bus_sensor <= 2'd0;
            r_bus_reg    <= 2'd0;
            r_overrun    <= 1'b0;
            r_timeout    <= 1'b0;
            for (int i = 0; i < N_AXES; i++)    r_shadow[i] <= '0;
            for (int i = 0; i < N_SENSORS; i++) r_data[i]   <= '0;
        end else begin
            r_bus_start <= 1'b0;
            r_timeout   <= w_abort;
            r_overrun   <= |(w_drdy & r_pending);
            // Clear before set: a drdy coinciding with a clear keeps pending.
            r_pending   <= (r_pending & ~((w_commit || w_abort) ? w_grant_oh : 3'b000))
                         | w_drdy;
            r_ready     <= (r_ready & ~w_read) | (w_commit ? w_grant_oh : 3'b000);

            for (int i = 0; i < N_SENSORS; i++) begin
                if (w_commit && w_grant_oh[i]) begin
                    r_data[i] <= {r_shadow[2], r_shadow[1], r_shadow[0]};
                end
            end

            case (r_state)
                IDLE: begin
                    if (configured && w_grant_valid) begin
                        r_grant      <= w_grant;
                        r_axis       <= 2'd0;
                        r_bus_start  <= 1'b1;
                        r_bus_sensor <= w_grant;
                        r_bus_reg    <= 2'd0;
                        r_state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    if (bus_done) begin
                        r_shadow[r_axis] <= bus_rdata;
                        if (r_axis == 2'd2) begin
                            r_state <= COMMIT;
                        end else begin
                            r_axis       <= r_axis + 2'd1;
                            r_bus_start  <= 1'b1;
                            r_bus_sensor <= r_grant;
                            r_bus_reg    <= r_axis + 2'd1;
                            r_state      <= ISSUE;
                        end
                    end else begin
                        if (r_cnt != c_CNT_MAX) r_cnt <= r_cnt + c_CNT_W'(1);
                        if (w_abort) begin
                            r_last  <= r_grant;
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_last  <= r_grant;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus_start   = r_bus_start;
    assign bus_sensor  = r_bus_sensor;
    assign bus_reg     = r_bus_reg;
    assign acc_ready   = r_ready[0];
    assign gyro_ready  = r_ready[1];
    assign mag_ready   = r_ready[2];
    assign acc_data    = r_data[0];
    assign gyro_data   = r_data[1];
    assign mag_data    = r_data[2];
    assign overrun     = r_overrun;
    assign bus_timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_sensor_read_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_sensor_read_scheduler
//  Description : Scoreboard bench for sensor_read_scheduler. Stimulus pushes
//                expected bus requests, publish events, overrun and timeout
//                pulses; a monitor pops and compares as the DUT presents them.
//                A responder answers bus requests from a queue of read words.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sensor_read_scheduler;

    localparam int c_TIMEOUT = 4;
    localparam int c_START = 0, c_READY = 1, c_OVR = 2, c_TMO = 3;

    typedef struct {
        int          kind;
        int          sensor;
        logic [47:0] val;
    } ev_t;

    logic        clk = 1'b0;
    logic        n_rst, configured;
    logic        acc_drdy, gyro_drdy, mag_drdy;
    logic        bus_start;
    logic [1:0]  bus_sensor, bus_reg;
    logic        bus_done;
    logic [15:0] bus_rdata;
    logic        acc_ready, gyro_ready, mag_ready;
    logic        acc_read, gyro_read, mag_read;
    logic [47:0] acc_data, gyro_data, mag_data;
    logic        overrun, bus_timeout;

    ev_t         exp_q[$];
    logic [15:0] rdata_q[$];
    int          checks = 0;
    int          errors = 0;
    int          stale_req = 0;
    int          stale_done = 0;

    always #5 clk = ~clk;

    sensor_read_scheduler #(.TIMEOUT(c_TIMEOUT)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .configured  (configured),
        .acc_drdy    (acc_drdy),
        .gyro_drdy   (gyro_drdy),
        .mag_drdy    (mag_drdy),
        .bus_start   (bus_start),
        .bus_sensor  (bus_sensor),
        .bus_reg     (bus_reg),
        .bus_done    (bus_done),
        .bus_rdata   (bus_rdata),
        .acc_ready   (acc_ready),
        .gyro_ready  (gyro_ready),
        .mag_ready   (mag_ready),
        .acc_read    (acc_read),
        .gyro_read   (gyro_read),
        .mag_read    (mag_read),
        .acc_data    (acc_data),
        .gyro_data   (gyro_data),
        .mag_data    (mag_data),
        .overrun     (overrun),
        .bus_timeout (bus_timeout)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, exp);
        end
    endtask

    task automatic observe(input int kind, input int sensor, input logic [47:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d sensor=%0d val=%h, required none",
                     kind, sensor, val);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.sensor != sensor || e.val !== val) begin
                errors++;
                $display("FAIL scoreboard: got kind=%0d sensor=%0d val=%h, required kind=%0d sensor=%0d val=%h",
                         kind, sensor, val, e.kind, e.sensor, e.val);
            end
        end
    endtask

    task automatic expect_ev(input int kind, input int sensor, input logic [47:0] val);
        ev_t e;
        e.kind = kind; e.sensor = sensor; e.val = val;
        exp_q.push_back(e);
    endtask

    // Expect a full three-word service of one sensor and queue the read words.
    task automatic expect_service(input int sensor, input logic [15:0] x,
                                  input logic [15:0] y, input logic [15:0] z);
        for (int a = 0; a < 3; a++) expect_ev(c_START, sensor, 48'(a));
        expect_ev(c_READY, sensor, {z, y, x});
        rdata_q.push_back(x);
        rdata_q.push_back(y);
        rdata_q.push_back(z);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] m);
        {mag_drdy, gyro_drdy, acc_drdy} = m;
        tick;
        {mag_drdy, gyro_drdy, acc_drdy} = 3'b000;
    endtask

    task automatic ack(input logic [2:0] m);
        {mag_read, gyro_read, acc_read} = m;
        tick;
        {mag_read, gyro_read, acc_read} = 3'b000;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick;
            n++;
        end
        chk(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    task automatic check_zero(input string name);
        chk({name, "_ctrl"}, 64'({bus_start, bus_sensor, bus_reg, acc_ready, gyro_ready,
                                  mag_ready, overrun, bus_timeout}), 64'd0);
        chk({name, "_acc"},  64'(acc_data),  64'd0);
        chk({name, "_gyro"}, 64'(gyro_data), 64'd0);
        chk({name, "_mag"},  64'(mag_data),  64'd0);
    endtask

    task automatic do_reset;
        n_rst = 1'b0;
        {acc_drdy, gyro_drdy, mag_drdy} = 3'b000;
        {acc_read, gyro_read, mag_read} = 3'b000;
        tick;
        tick;
        check_zero("reset");
        n_rst = 1'b1;
    endtask

    // Monitor: every DUT output event is matched against the scoreboard.
    initial begin
        logic [2:0] prev_rdy;
        prev_rdy = 3'b000;
        forever begin
            @(negedge clk);
            if (bus_start)               observe(c_START, int'(bus_sensor), 48'(bus_reg));
            if (acc_ready  && !prev_rdy[0]) observe(c_READY, 0, acc_data);
            if (gyro_ready && !prev_rdy[1]) observe(c_READY, 1, gyro_data);
            if (mag_ready  && !prev_rdy[2]) observe(c_READY, 2, mag_data);
            if (overrun)                 observe(c_OVR, 0, 48'd0);
            if (bus_timeout)             observe(c_TMO, 0, 48'd0);
            prev_rdy = {mag_ready, gyro_ready, acc_ready};
        end
    end

    // Bus responder: answers one cycle after each start while words are queued.
    initial begin
        bus_done  = 1'b0;
        bus_rdata = 16'h0000;
        forever begin
            @(negedge clk);
            if (bus_start && rdata_q.size() > 0) begin
                @(posedge clk); #1;
                bus_done  = 1'b1;
                bus_rdata = rdata_q.pop_front();
                @(posedge clk); #1;
                bus_done  = 1'b0;
                bus_rdata = 16'h0000;
            end else if (stale_done != stale_req) begin
                stale_done++;
                @(posedge clk); #1;
                bus_done  = 1'b1;
                bus_rdata = 16'hDEAD;
                @(posedge clk); #1;
                bus_done  = 1'b0;
                bus_rdata = 16'h0000;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_rst      = 1'b0;
        configured = 1'b1;
        {acc_drdy, gyro_drdy, mag_drdy} = 3'b000;
        {acc_read, gyro_read, mag_read} = 3'b000;

        // Reset and quiet idle
        do_reset;
        for (int i = 0; i < 10; i++) begin
            tick;
            chk("idle_no_start", 64'(bus_start), 64'd0);
        end

        // Single ACC with best-case latency
        expect_service(0, 16'h0011, 16'h0022, 16'h0033);
        pulse(3'b001);
        repeat (7) tick;
        chk("acc_ready_cycle7", 64'(acc_ready), 64'd0);
        tick;
        chk("acc_ready_cycle8", 64'(acc_ready), 64'd1);
        chk("acc_data", 64'(acc_data), 64'h0000_0033_0022_0011);
        drain("acc_drain", 10);
        ack(3'b001);
        chk("acc_read_clear", 64'(acc_ready), 64'd0);
        ack(3'b001);
        chk("acc_read_noop", 64'(acc_ready), 64'd0);

        // Round-robin from reset, twice
        do_reset;
        expect_service(0, 16'hA001, 16'hA002, 16'hA003);
        expect_service(1, 16'hB001, 16'hB002, 16'hB003);
        expect_service(2, 16'hC001, 16'hC002, 16'hC003);
        pulse(3'b111);
        drain("rr1_drain", 100);
        ack(3'b111);
        chk("rr1_ack", 64'({mag_ready, gyro_ready, acc_ready}), 64'd0);
        expect_service(0, 16'h1A1A, 16'h2A2A, 16'h3A3A);
        expect_service(1, 16'h1B1B, 16'h2B2B, 16'h3B3B);
        expect_service(2, 16'h1C1C, 16'h2C2C, 16'h3C3C);
        pulse(3'b111);
        drain("rr2_drain", 100);
        chk("rr2_gyro_data", 64'(gyro_data), 64'h0000_3B3B_2B2B_1B1B);
        ack(3'b111);

        // Backpressure and overrun
        expect_service(0, 16'h0D01, 16'h0D02, 16'h0D03);
        pulse(3'b001);
        drain("bp_first", 40);
        pulse(3'b001);
        repeat (5) tick;
        expect_ev(c_OVR, 0, 48'd0);
        pulse(3'b001);
        repeat (3) tick;
        drain("bp_overrun", 5);
        chk("bp_ready_held", 64'(acc_ready), 64'd1);
        chk("bp_data_kept", 64'(acc_data), 64'h0000_0D03_0D02_0D01);
        expect_service(0, 16'h0E01, 16'h0E02, 16'h0E03);
        ack(3'b001);
        drain("bp_after_read", 40);
        chk("bp_new_data", 64'(acc_data), 64'h0000_0E03_0E02_0E01);

        // Timeout on GYRO, then MAG served normally
        expect_ev(c_START, 1, 48'd0);
        expect_ev(c_TMO, 0, 48'd0);
        pulse(3'b010);
        tick;
        tick;
        repeat (3) tick;
        chk("tmo_early", 64'(bus_timeout), 64'd0);
        tick;
        chk("tmo_pulse", 64'(bus_timeout), 64'd1);
        chk("tmo_no_ready", 64'(gyro_ready), 64'd0);
        tick;
        chk("tmo_one_cycle", 64'(bus_timeout), 64'd0);
        drain("tmo_drain", 5);
        expect_service(2, 16'h0F01, 16'h0F02, 16'h0F03);
        pulse(3'b100);
        drain("tmo_mag", 40);
        chk("tmo_gyro_still", 64'(gyro_ready), 64'd0);

        // configured low blocks new grants
        configured = 1'b0;
        pulse(3'b010);
        repeat (10) tick;
        chk("cfg_blocked", 64'(gyro_ready), 64'd0);
        expect_service(1, 16'h7001, 16'h7002, 16'h7003);
        configured = 1'b1;
        drain("cfg_resume", 40);

        // Reset while WAIT is on axis 1; stale bus_done afterwards
        ack(3'b111);
        expect_ev(c_START, 0, 48'd0);
        expect_ev(c_START, 0, 48'd1);
        rdata_q.push_back(16'h1234);
        pulse(3'b001);
        drain("mid_wait_reach", 20);
        n_rst = 1'b0;
        tick;
        check_zero("mid_wait_reset");
        n_rst = 1'b1;
        stale_req++;
        repeat (20) tick;
        chk("stale_no_ready", 64'(acc_ready), 64'd0);
        chk("stale_no_data", 64'(acc_data), 64'd0);
        chk("rdata_left", 64'(rdata_q.size()), 64'd0);
        chk("exp_left", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
